seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, registered successor to the team's four-bit combinational ALU. Accepts one operation at a time over a valid/ready input handshake, computes ADD, SUB, AND, OR, XOR, compare, and an optional multi-cycle shift-add multiply. Returns the result with registered Eq/Gt/Lt flags over a valid/ready output handshake. Sits between an operand sequencer and a result consumer in the datapath.

## Interface
- WIDTH, 4, operand width in bits (≥2).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 CMP, 110 MUL, 111 reserved.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes result.
- y  out  2*WIDTH  result, zero-extended.
- eq, gt, lt  out  1 each  unsigned compare of the accepted a and b.
- err  out  1  illegal or compiled-out op.

## Operation
- Operands are captured on the accept edge (in_valid && in_ready). Later changes on a, b and op have no effect.
- ADD: y = a + b, carry in bit WIDTH.
- SUB: y[WIDTH:0] = (a − b) mod 2^(WIDTH+1), two's complement with the borrow/sign in bit WIDTH; upper bits 0.
- AND/OR/XOR: bitwise in y[WIDTH-1:0]; upper bits 0.
- CMP: y = 0; only the flags carry information.
- MUL: y = a × b, full 2*WIDTH product, computed by shift-add with one partial product per cycle.
- eq/gt/lt are computed for every legal op. Exactly one of them is 1.
- Illegal op: y = 0, eq = gt = lt = 0, err = 1. For legal ops err = 0.
- State machine:
  - IDLE → DONE on accept of a non-MUL op.
  - IDLE → BUSY on accept of MUL.
  - BUSY → DONE after WIDTH iterations.
  - DONE → IDLE on out_ready.
  - IDLE holds while in_valid is low.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- While out_valid is high and out_ready is low, y, eq, gt, lt and err hold stable.
- Result registers keep their last values after the DONE → IDLE handoff.

## Timing
- Reset values:
  - state IDLE, so in_ready = 1.
  - out_valid, y, eq, gt, lt, err = 0.
  - Multiply accumulator and iteration counter = 0.
- rst_n low at any time, including mid-MUL or in DONE: the block aborts immediately and the result is discarded. No accept occurs while rst_n is low.
- Latency from the accept edge to out_valid high:
  - Non-MUL ops: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Throughput:
  - With out_ready tied high, one non-MUL op every 2 cycles: accept, DONE, then IDLE.
  - MUL: one op every WIDTH+2 cycles.
- in_ready and out_valid are never high in the same cycle.
- The iteration counter is $clog2(WIDTH)+1 bits and does not wrap within an operation.

## Configuration
- SEQ_ALU_MUL_EN defined:
  - op 110 performs MUL through the BUSY state.
- SEQ_ALU_MUL_EN undefined:
  - BUSY, the accumulator and the counter are not built.
  - op 110 is treated as illegal: 1-cycle latency, y = 0, err = 1.
- op 111 is always illegal, with or without the macro.

## Test plan
All scenarios use WIDTH=4.
- ADD a=1111, b=1111, out_ready=1 → one cycle later out_valid=1, y=8'h1E, eq=1, gt=0, lt=0, err=0.
- SUB a=0011, b=0101 → y=8'h1E (5'b11110), lt=1. Then SUB a=1111, b=0000 → y=8'h0F, gt=1.
- MUL a=1111, b=1111, with SEQ_ALU_MUL_EN defined → in_ready=0 for 5 cycles, then out_valid=1 with y=8'hE1 on cycle 5 after accept, eq=1. Without the macro → y=0, err=1 after 1 cycle.
- Backpressure: AND a=1100, b=1010, out_ready held low for 3 cycles → y=8'h08 held stable, out_valid=1, in_ready=0 throughout. Then out_ready=1 → IDLE on the next edge, in_ready=1.
- Reset mid-MUL: assert rst_n=0 two cycles after accepting a MUL → out_valid=0, y=0, in_ready=1 immediately. After release, XOR a=1010, b=0110 → y=8'h0C, gt=1.
- Illegal op 111 with a=0101, b=0101 → y=0, eq=gt=lt=0, err=1, 1-cycle latency. A following CMP of the same operands → err=0, eq=1.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ADD/SUB/AND/OR/XOR/CMP unit behind valid/ready handshakes.
// Define SEQ_ALU_MUL_EN to build the shift-add multiplier for op 110.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               eq,
  output logic               gt,
  output logic               lt,
  output logic               err
);

  localparam int YW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [YW-1:0] ZERO_Y = {YW{1'b0}};
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

  state_t          state_q, state_d;
  logic [YW-1:0]   y_q, y_d;
  logic            eq_q, eq_d, gt_q, gt_d, lt_q, lt_d, err_q, err_d;
  logic [WIDTH:0]  sum_s, diff_s;
  logic [YW-1:0]   res_y_s;
  logic            res_eq_s, res_gt_s, res_lt_s, res_err_s;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);
  logic [YW-1:0]    acc_q, acc_d, mcand_q, mcand_d, acc_step_s;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       flg_q, flg_d;

  assign acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y   = y_q;
  assign eq  = eq_q;
  assign gt  = gt_q;
  assign lt  = lt_q;
  assign err = err_q;

  // Single-cycle result of the op currently on the inputs; used only on accept.
  always_comb begin
    res_y_s   = ZERO_Y;
    res_eq_s  = (a == b);
    res_gt_s  = (a > b);
    res_lt_s  = (a < b);
    res_err_s = 1'b0;
    case (op)
      OP_ADD: res_y_s[WIDTH:0]   = sum_s;
      OP_SUB: res_y_s[WIDTH:0]   = diff_s;
      OP_AND: res_y_s[WIDTH-1:0] = a & b;
      OP_OR:  res_y_s[WIDTH-1:0] = a | b;
      OP_XOR: res_y_s[WIDTH-1:0] = a ^ b;
      OP_CMP: res_y_s = ZERO_Y;
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: res_y_s = ZERO_Y;
`endif
      default: begin
        res_y_s   = ZERO_Y;
        res_eq_s  = 1'b0;
        res_gt_s  = 1'b0;
        res_lt_s  = 1'b0;
        res_err_s = 1'b1;
      end
    endcase
  end

  // Next-state and result-register update; outputs hold until the next DONE.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    err_d   = err_q;
`ifdef SEQ_ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    flg_d    = flg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DONE;
          y_d     = res_y_s;
          eq_d    = res_eq_s;
          gt_d    = res_gt_s;
          lt_d    = res_lt_s;
          err_d   = res_err_s;
`ifdef SEQ_ALU_MUL_EN
          if (op == OP_MUL) begin
            state_d  = S_BUSY;
            y_d      = y_q;
            eq_d     = eq_q;
            gt_d     = gt_q;
            lt_d     = lt_q;
            err_d    = err_q;
            acc_d    = ZERO_Y;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = ZERO_C;
            flg_d    = {res_eq_s, res_gt_s, res_lt_s};
          end else begin
            state_d = S_DONE;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      S_BUSY: begin
        acc_d    = acc_step_s;
        mcand_d  = {mcand_q[YW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + ONE_C;
        // Final partial product lands straight in y so DONE follows WIDTH busy cycles.
        if (cnt_q == LAST_C) begin
          state_d = S_DONE;
          y_d     = acc_step_s;
          eq_d    = flg_q[2];
          gt_d    = flg_q[1];
          lt_d    = flg_q[0];
          err_d   = 1'b0;
        end else begin
          state_d = S_BUSY;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= ZERO_Y;
      eq_q  <= 1'b0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      eq_q  <= eq_d;
      gt_q  <= gt_d;
      lt_q  <= lt_d;
      err_q <= err_d;
    end
  end

`ifdef SEQ_ALU_MUL_EN
  // Shift-add multiplier working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= ZERO_Y;
      mcand_q  <= ZERO_Y;
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= ZERO_C;
      flg_q    <= 3'b000;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      flg_q    <= flg_d;
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=4); expectations follow SEQ_ALU_MUL_EN.
module tb_seq_alu;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = 3'd0;
  logic         in_ready, out_valid, eq, gt, lt, err;
  logic [2*W-1:0] y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] v;   // {y, eq, gt, lt, err}
    int          lat;
  } exp_t;
  exp_t sb[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .eq(eq), .gt(gt), .lt(lt), .err(err)
  );

  always #5 clk = ~clk;

  // in_ready and out_valid must never be high together.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (in_ready && out_valid) begin
        errors++;
        $display("FAIL handshake_excl in_ready=%0b out_valid=%0b", in_ready, out_valid);
      end
    end
  end

  function automatic exp_t model(input logic [2:0] o, input logic [3:0] x, input logic [3:0] z);
    exp_t e;
    int xi, zi, lat;
    logic [7:0] ry;
    logic feq, fgt, flt, ferr;
    xi = x; zi = z; lat = 1;
    ry = 8'h00; feq = (xi == zi); fgt = (xi > zi); flt = (xi < zi); ferr = 1'b0;
    case (o)
      3'd0: ry = 8'(xi + zi);
      3'd1: ry = 8'((xi - zi) & 31);
      3'd2: ry = {4'h0, x & z};
      3'd3: ry = {4'h0, x | z};
      3'd4: ry = {4'h0, x ^ z};
      3'd5: ry = 8'h00;
`ifdef SEQ_ALU_MUL_EN
      3'd6: begin ry = 8'(xi * zi); lat = W + 1; end
`endif
      default: begin ry = 8'h00; feq = 1'b0; fgt = 1'b0; flt = 1'b0; ferr = 1'b1; end
    endcase
    e.v = {ry, feq, fgt, flt, ferr};
    e.lat = lat;
    return e;
  endfunction

  task automatic send(input logic [2:0] o, input logic [3:0] x, input logic [3:0] z);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; op = o; a = x; b = z;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
    sb.push_back(model(o, x, z));
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 1;
    while (!out_valid && lat <= 20) begin @(posedge clk); #1; lat++; end
    ok = out_valid;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, y, eq, gt, lt, err} !== {1'b1, 1'b0, 8'h00, 4'h0}) begin
      errors++;
      $display("FAIL reset got rdy=%0b vld=%0b y=%h flags=%b%b%b%b", in_ready, out_valid, y, eq, gt, lt, err);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_arith();
    exp_t e; int lat; bit ok;
    logic [2:0] ops [3] = '{3'd0, 3'd1, 3'd1};
    logic [3:0] xs  [3] = '{4'hF, 4'h3, 4'hF};
    logic [3:0] zs  [3] = '{4'hF, 4'h5, 4'h0};
    for (int i = 0; i < 3; i++) begin
      send(ops[i], xs[i], zs[i]);
      wait_valid(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != e.lat) begin errors++; $display("FAIL arith_lat[%0d] got %0d want %0d", i, lat, e.lat); end
      checks++;
      if ({y, eq, gt, lt, err} !== e.v) begin
        errors++; $display("FAIL arith_res[%0d] got %h want %h", i, {y, eq, gt, lt, err}, e.v);
      end
    end
  endtask

  task automatic test_mul();
    exp_t e; int lat;
    send(3'd6, 4'hF, 4'hF);
    lat = 1;
    while (!out_valid && lat <= 20) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_ready got %b want 0 at %0d", in_ready, lat); end
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    checks++;
    if (!out_valid || lat != e.lat) begin errors++; $display("FAIL mul_lat got %0d want %0d", lat, e.lat); end
    checks++;
    if ({y, eq, gt, lt, err} !== e.v) begin errors++; $display("FAIL mul_res got %h want %h", {y, eq, gt, lt, err}, e.v); end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_idle got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    exp_t e; int lat; bit ok;
    out_ready = 1'b0;
    send(3'd2, 4'hC, 4'hA);
    wait_valid(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || {y, eq, gt, lt, err} !== e.v) begin errors++; $display("FAIL bp_res got %h want %h", {y, eq, gt, lt, err}, e.v); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, y, eq, gt, lt, err} !== {2'b10, e.v}) begin
        errors++; $display("FAIL bp_hold[%0d] got vld=%b rdy=%b y=%h", i, out_valid, in_ready, y);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, y} !== {2'b10, 8'h08}) begin
      errors++; $display("FAIL bp_release got rdy=%b vld=%b y=%h want 1 0 08", in_ready, out_valid, y);
    end
  endtask

  task automatic test_reset_mid_mul();
    exp_t e; int lat; bit ok;
    send(3'd6, 4'h9, 4'h7);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({out_valid, in_ready, y, err} !== {2'b01, 8'h00, 1'b0}) begin
      errors++; $display("FAIL rst_mid got vld=%b rdy=%b y=%h err=%b want 0 1 00 0", out_valid, in_ready, y, err);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(3'd4, 4'hA, 4'h6);
    wait_valid(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != e.lat || {y, eq, gt, lt, err} !== e.v) begin
      errors++; $display("FAIL rst_xor got %h lat %0d want %h", {y, eq, gt, lt, err}, lat, e.v);
    end
  endtask

  task automatic test_illegal();
    exp_t e; int lat; bit ok;
    for (int i = 0; i < 2; i++) begin
      send(i == 0 ? 3'd7 : 3'd5, 4'h5, 4'h5);
      wait_valid(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != e.lat || {y, eq, gt, lt, err} !== e.v) begin
        errors++; $display("FAIL illegal_cmp[%0d] got %h lat %0d want %h", i, {y, eq, gt, lt, err}, lat, e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; bit ok;
    for (int i = 0; i < 24; i++) begin
      send(3'($urandom_range(7, 0)), 4'($urandom), 4'($urandom));
      wait_valid(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != e.lat) begin errors++; $display("FAIL b2b_lat[%0d] got %0d want %0d", i, lat, e.lat); end
      checks++;
      if ({y, eq, gt, lt, err} !== e.v) begin
        errors++; $display("FAIL b2b_res[%0d] got %h want %h", i, {y, eq, gt, lt, err}, e.v);
      end
      checks++;
      if (!e.v[0] && (eq + gt + lt) != 1) begin errors++; $display("FAIL b2b_onehot[%0d] got %b%b%b", i, eq, gt, lt); end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle[%0d] got %b want 1", i, in_ready); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arith();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
